// File: rtl/fetch_controller_if.sv
// Bundles the instruction-memory port, the IF/ID handshake, the redirect
// request and the fetch status into one connection between fetch and its neighbours.
interface fetch_controller_if;
    logic [31:0] FetchAddress;
    logic [31:0] FetchInstruction;
    logic        IF_Ready;
    logic        IF_Valid;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PC;
    logic [31:0] IF_PCPlus4;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic        Halted;
    logic        Fault;
    logic [31:0] FetchCount;

    modport master (
        output FetchAddress,
        input  FetchInstruction,
        input  IF_Ready,
        output IF_Valid,
        output IF_Instruction,
        output IF_PC,
        output IF_PCPlus4,
        input  Redirect,
        input  RedirectTarget,
        output Halted,
        output Fault,
        output FetchCount
    );

    modport slave (
        input  FetchAddress,
        output FetchInstruction,
        output IF_Ready,
        input  IF_Valid,
        input  IF_Instruction,
        input  IF_PC,
        input  IF_PCPlus4,
        output Redirect,
        output RedirectTarget,
        input  Halted,
        input  Fault,
        input  FetchCount
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch: owns the PC, reads a combinational word memory and holds
// the fetched word in an IF/ID register with valid/ready flow control.
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 296
) (
    input logic                Clk,
    input logic                Reset,
    fetch_controller_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } state_e;

    localparam logic [31:0] WORD_LIMIT = 32'(MEM_WORDS);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        load;
    logic [31:0] instr_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_pc4_q;
    logic [31:0] count_q;
    logic        pc_oob;
    logic        target_bad;
    logic        accept;

    function automatic logic word_oob(input logic [31:0] addr);
        return {2'b00, addr[31:2]} >= WORD_LIMIT;
    endfunction

    assign pc_oob     = word_oob(pc_q);
    assign target_bad = (bus.RedirectTarget[1:0] != 2'b00) || word_oob(bus.RedirectTarget);
    assign accept     = valid_q && bus.IF_Ready;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    // Redirect outranks everything; running off the end drains the IF stage
    // before halting so a still-pending word is never dropped.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (bus.Redirect) begin
                    valid_d = 1'b0;
                    if (target_bad) begin
                        state_d = S_FAULT;
                    end else begin
                        pc_d = bus.RedirectTarget;
                    end
                end else if (pc_oob) begin
                    if (accept) begin
                        valid_d = 1'b0;
                    end
                    if (!valid_q || bus.IF_Ready) begin
                        state_d = S_HALT;
                    end
                end else if (!valid_q || bus.IF_Ready) begin
                    load    = 1'b1;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                end
            end
            S_HALT: begin
                valid_d = 1'b0;
                if (bus.Redirect) begin
                    if (target_bad) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_RUN;
                        pc_d    = bus.RedirectTarget;
                    end
                end
            end
            S_FAULT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // IF/ID stage boundary
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            instr_q  <= 32'd0;
            if_pc_q  <= 32'd0;
            if_pc4_q <= 32'd0;
            count_q  <= 32'd0;
        end else if (load) begin
            instr_q  <= bus.FetchInstruction;
            if_pc_q  <= pc_q;
            if_pc4_q <= pc_q + 32'd4;
            count_q  <= count_q + 32'd1;
        end
    end

    always_comb begin
        bus.FetchAddress   = pc_q;
        bus.IF_Valid       = valid_q;
        bus.IF_Instruction = instr_q;
        bus.IF_PC          = if_pc_q;
        bus.IF_PCPlus4     = if_pc4_q;
        bus.Halted         = (state_q == S_HALT);
        bus.Fault          = (state_q == S_FAULT);
        bus.FetchCount     = count_q;
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus a randomized
// ready/redirect run checked against an in-order expected-stream model.
module tb_fetch_controller;

    localparam int MW = 296;
    localparam logic [31:0] HI_PC = 32'((MW - 2) * 4);

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic Reset2 = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] mem [MW];

    fetch_controller_if bus1 ();
    fetch_controller_if bus2 ();

    fetch_controller #(.RESET_PC(32'h0), .MEM_WORDS(MW)) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus1)
    );

    fetch_controller #(.RESET_PC(HI_PC), .MEM_WORDS(MW)) dut_hi (
        .Clk(Clk), .Reset(Reset2), .bus(bus2)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a[31:2] < 30'(MW)) return mem[int'(a[31:2])];
        return 32'hDEAD_BEEF;
    endfunction

    assign bus1.FetchInstruction = mem_rd(bus1.FetchAddress);
    assign bus2.FetchInstruction = mem_rd(bus2.FetchAddress);

    task automatic test_reset();
        for (int i = 0; i < MW; i++) mem[i] = 32'(i);
        Reset = 1'b1;
        bus1.IF_Ready = 1'b0; bus1.Redirect = 1'b0; bus1.RedirectTarget = 32'h0;
        bus2.IF_Ready = 1'b0; bus2.Redirect = 1'b0; bus2.RedirectTarget = 32'h0;
        #3;
        checks++;
        if ({bus1.IF_Valid, bus1.IF_Instruction, bus1.IF_PC, bus1.IF_PCPlus4, bus1.Halted, bus1.Fault, bus1.FetchCount} !== '0) begin
            failures++; $display("FAIL reset_outputs valid=%0b instr=%0h pc=%0h pc4=%0h halt=%0b fault=%0b cnt=%0d required all zero",
                bus1.IF_Valid, bus1.IF_Instruction, bus1.IF_PC, bus1.IF_PCPlus4, bus1.Halted, bus1.Fault, bus1.FetchCount);
        end
        checks++;
        if (bus1.FetchAddress !== 32'h0) begin
            failures++; $display("FAIL reset_addr got=%0h exp=0", bus1.FetchAddress);
        end
    endtask

    task automatic test_sequential();
        bus1.IF_Ready = 1'b1;
        @(negedge Clk); Reset = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if (bus1.IF_Valid !== 1'b0) begin failures++; $display("FAIL seq_idle_valid got=%0b exp=0", bus1.IF_Valid); end
        for (int k = 0; k < 3; k++) begin
            @(posedge Clk); #1;
            checks++;
            if (bus1.IF_Valid !== 1'b1 || bus1.IF_PC !== 32'(4 * k) || bus1.IF_Instruction !== 32'(k) || bus1.IF_PCPlus4 !== 32'(4 * k + 4)) begin
                failures++; $display("FAIL seq_load%0d valid=%0b pc=%0h instr=%0h pc4=%0h exp pc=%0h instr=%0h", k,
                    bus1.IF_Valid, bus1.IF_PC, bus1.IF_Instruction, bus1.IF_PCPlus4, 4 * k, k);
            end
        end
        checks++;
        if (bus1.FetchCount !== 32'd3) begin failures++; $display("FAIL seq_count got=%0d exp=3", bus1.FetchCount); end
    endtask

    task automatic test_stall();
        bus1.IF_Ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge Clk); #1;
            checks++;
            if (bus1.IF_Valid !== 1'b1 || bus1.IF_PC !== 32'd8 || bus1.FetchAddress !== 32'd12) begin
                failures++; $display("FAIL stall_hold%0d valid=%0b pc=%0h addr=%0h exp valid=1 pc=8 addr=c", k,
                    bus1.IF_Valid, bus1.IF_PC, bus1.FetchAddress);
            end
        end
        bus1.IF_Ready = 1'b1;
        @(posedge Clk); #1;
        checks++;
        if (bus1.IF_PC !== 32'd12 || bus1.IF_Instruction !== 32'd3 || bus1.FetchCount !== 32'd4) begin
            failures++; $display("FAIL stall_release pc=%0h instr=%0h cnt=%0d exp pc=c instr=3 cnt=4",
                bus1.IF_PC, bus1.IF_Instruction, bus1.FetchCount);
        end
    endtask

    task automatic test_redirect();
        bus1.Redirect = 1'b1; bus1.RedirectTarget = 32'h40; bus1.IF_Ready = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if (bus1.IF_Valid !== 1'b0 || bus1.FetchAddress !== 32'h40) begin
            failures++; $display("FAIL redir_flush valid=%0b addr=%0h exp valid=0 addr=40", bus1.IF_Valid, bus1.FetchAddress);
        end
        bus1.Redirect = 1'b0; bus1.IF_Ready = 1'b1;
        @(posedge Clk); #1;
        checks++;
        if (bus1.IF_Valid !== 1'b1 || bus1.IF_PC !== 32'h40 || bus1.IF_Instruction !== 32'd16 || bus1.FetchCount !== 32'd5) begin
            failures++; $display("FAIL redir_load valid=%0b pc=%0h instr=%0h cnt=%0d exp 1/40/10/5",
                bus1.IF_Valid, bus1.IF_PC, bus1.IF_Instruction, bus1.FetchCount);
        end
    endtask

    task automatic test_fault();
        bus1.Redirect = 1'b1; bus1.RedirectTarget = 32'h42;
        @(posedge Clk); #1;
        checks++;
        if (bus1.Fault !== 1'b1 || bus1.IF_Valid !== 1'b0 || bus1.FetchAddress !== 32'h44) begin
            failures++; $display("FAIL fault_misalign fault=%0b valid=%0b addr=%0h exp 1/0/44", bus1.Fault, bus1.IF_Valid, bus1.FetchAddress);
        end
        bus1.RedirectTarget = 32'h0;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (bus1.Fault !== 1'b1 || bus1.FetchAddress !== 32'h44 || bus1.FetchCount !== 32'd5 || bus1.IF_Valid !== 1'b0) begin
            failures++; $display("FAIL fault_sticky fault=%0b addr=%0h cnt=%0d valid=%0b exp 1/44/5/0",
                bus1.Fault, bus1.FetchAddress, bus1.FetchCount, bus1.IF_Valid);
        end
        bus1.Redirect = 1'b0;
        Reset = 1'b1; #1;
        checks++;
        if (bus1.Fault !== 1'b0) begin failures++; $display("FAIL fault_reset_clear got=%0b exp=0", bus1.Fault); end
        @(negedge Clk); Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        bus1.Redirect = 1'b1; bus1.RedirectTarget = 32'(MW * 4);
        @(posedge Clk); #1;
        checks++;
        if (bus1.Fault !== 1'b1 || bus1.IF_Valid !== 1'b0 || bus1.Halted !== 1'b0) begin
            failures++; $display("FAIL fault_range fault=%0b valid=%0b halt=%0b exp 1/0/0", bus1.Fault, bus1.IF_Valid, bus1.Halted);
        end
        bus1.Redirect = 1'b0;
    endtask

    task automatic test_async_reset();
        bool_reached: begin end
        Reset = 1'b1;
        @(negedge Clk); Reset = 1'b0; bus1.IF_Ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk); #1;
            if (bus1.FetchCount == 32'd7) break;
        end
        bus1.IF_Ready = 1'b0;
        checks++;
        if (bus1.FetchCount !== 32'd7) begin failures++; $display("FAIL arst_reach_count got=%0d exp=7", bus1.FetchCount); end
        @(posedge Clk); #1;
        checks++;
        if (bus1.IF_Valid !== 1'b1 || bus1.FetchCount !== 32'd7) begin
            failures++; $display("FAIL arst_stall valid=%0b cnt=%0d exp 1/7", bus1.IF_Valid, bus1.FetchCount);
        end
        #2 Reset = 1'b1;
        #1;
        checks++;
        if ({bus1.IF_Valid, bus1.IF_Instruction, bus1.IF_PC, bus1.IF_PCPlus4, bus1.Halted, bus1.Fault, bus1.FetchCount, bus1.FetchAddress} !== '0) begin
            failures++; $display("FAIL arst_immediate valid=%0b pc=%0h cnt=%0d addr=%0h required all zero",
                bus1.IF_Valid, bus1.IF_PC, bus1.FetchCount, bus1.FetchAddress);
        end
        @(negedge Clk); Reset = 1'b0; bus1.IF_Ready = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (bus1.IF_Valid !== 1'b1 || bus1.IF_PC !== 32'h0 || bus1.FetchCount !== 32'd1) begin
            failures++; $display("FAIL arst_restart valid=%0b pc=%0h cnt=%0d exp 1/0/1", bus1.IF_Valid, bus1.IF_PC, bus1.FetchCount);
        end
    endtask

    task automatic test_halt();
        bus2.IF_Ready = 1'b1;
        @(negedge Clk); Reset2 = 1'b0;
        @(posedge Clk);
        for (int k = 0; k < 2; k++) begin
            @(posedge Clk); #1;
            checks++;
            if (bus2.IF_Valid !== 1'b1 || bus2.IF_PC !== HI_PC + 32'(4 * k) || bus2.IF_Instruction !== 32'(MW - 2 + k)) begin
                failures++; $display("FAIL halt_deliver%0d valid=%0b pc=%0h instr=%0h exp pc=%0h", k,
                    bus2.IF_Valid, bus2.IF_PC, bus2.IF_Instruction, HI_PC + 32'(4 * k));
            end
        end
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (bus2.Halted !== 1'b1 || bus2.IF_Valid !== 1'b0 || bus2.FetchCount !== 32'd2 || bus2.FetchAddress !== 32'(MW * 4)) begin
            failures++; $display("FAIL halt_state halt=%0b valid=%0b cnt=%0d addr=%0h exp 1/0/2/%0h",
                bus2.Halted, bus2.IF_Valid, bus2.FetchCount, bus2.FetchAddress, MW * 4);
        end
        bus2.Redirect = 1'b1; bus2.RedirectTarget = 32'h0;
        @(posedge Clk); #1;
        bus2.Redirect = 1'b0;
        checks++;
        if (bus2.Halted !== 1'b0 || bus2.FetchAddress !== 32'h0) begin
            failures++; $display("FAIL halt_resume halt=%0b addr=%0h exp 0/0", bus2.Halted, bus2.FetchAddress);
        end
        @(posedge Clk); #1;
        checks++;
        if (bus2.IF_Valid !== 1'b1 || bus2.IF_PC !== 32'h0 || bus2.IF_Instruction !== 32'h0) begin
            failures++; $display("FAIL halt_refetch valid=%0b pc=%0h instr=%0h exp 1/0/0", bus2.IF_Valid, bus2.IF_PC, bus2.IF_Instruction);
        end
    endtask

    // Model: decode must see an unbroken word stream from the last redirect
    // target (or reset PC), each word matching memory.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic        rdy;
        logic        redir;
        int          accepted;
        for (int i = 0; i < MW; i++) mem[i] = $urandom;
        Reset = 1'b1; bus1.IF_Ready = 1'b0; bus1.Redirect = 1'b0;
        @(negedge Clk); Reset = 1'b0;
        @(posedge Clk);
        exp_pc = 32'h0;
        accepted = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge Clk);
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 11) == 0) || (exp_pc > 32'((MW - 30) * 4));
            tgt   = 32'($urandom_range(0, MW - 1)) << 2;
            bus1.IF_Ready = rdy; bus1.Redirect = redir; bus1.RedirectTarget = tgt;
            #1;
            if (bus1.IF_Valid && rdy) begin
                checks++;
                if (bus1.IF_PC !== exp_pc || bus1.IF_Instruction !== mem[int'(exp_pc >> 2)] || bus1.IF_PCPlus4 !== exp_pc + 32'd4) begin
                    failures++; $display("FAIL rand_stream cyc=%0d pc=%0h instr=%0h pc4=%0h exp pc=%0h instr=%0h",
                        cyc, bus1.IF_PC, bus1.IF_Instruction, bus1.IF_PCPlus4, exp_pc, mem[int'(exp_pc >> 2)]);
                end
                exp_pc = exp_pc + 32'd4;
                accepted++;
            end
            if (redir) exp_pc = tgt;
        end
        bus1.Redirect = 1'b0;
        checks++;
        if (accepted < 150 || bus1.Halted !== 1'b0 || bus1.Fault !== 1'b0) begin
            failures++; $display("FAIL rand_progress accepted=%0d halt=%0b fault=%0b exp >=150/0/0", accepted, bus1.Halted, bus1.Fault);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_fault();
        test_async_reset();
        test_halt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the 32-bit word-addressed instruction memory (combinational read, MEM_WORDS deep).
- Owns the PC and drives the memory address each cycle.
- Registers the fetched word into an IF/ID output stage with a valid/ready handshake toward decode.
- Handles branch/jump redirects, end-of-program halt and bad-target faults.

Parameters:
RESET_PC, 32'h00000000, byte address fetched first after reset
MEM_WORDS, 296, instruction memory depth in words; legal word index 0..MEM_WORDS-1

Ports:
Clk  input  1  single clock, all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
FetchAddress  output  32  byte address to instruction memory; always equals PC
FetchInstruction  input  32  word returned by memory for FetchAddress, same cycle
IF_Ready  input  1  decode accepts IF stage this cycle
IF_Valid  output  1  IF stage holds a valid instruction
IF_Instruction  output  32  registered instruction
IF_PC  output  32  byte address of IF_Instruction
IF_PCPlus4  output  32  IF_PC + 4
Redirect  input  1  branch/jump taken; flush and load RedirectTarget
RedirectTarget  input  32  new byte PC
Halted  output  1  sequential fetch ran past last word
Fault  output  1  redirect to misaligned or out-of-range target; sticky
FetchCount  output  32  number of instructions loaded into IF stage since reset

Behaviour:
- Reset (async, any time, mid-operation included):
  - PC=RESET_PC; state=IDLE.
  - IF_Valid=0; IF_Instruction=0; IF_PC=0; IF_PCPlus4=0.
  - Halted=0; Fault=0; FetchCount=0.
- FetchAddress = PC combinationally in every state. Memory is read with PC[31:2]; PC[1:0] is always 0 in the legal states.
- States: IDLE, RUN, HALT, FAULT. Halted=(state==HALT); Fault=(state==FAULT).
- IDLE: first rising edge after Reset deasserts -> RUN. No load this edge.
- RUN, per edge, in priority order:
  1. Redirect=1:
     - IF_Valid<=0 (flush; the in-flight fetch is discarded).
     - If RedirectTarget[1:0]!=0 or RedirectTarget[31:2]>=MEM_WORDS: state<=FAULT, PC unchanged.
     - Else PC<=RedirectTarget.
  2. PC[31:2]>=MEM_WORDS (reached sequentially):
     - No load.
     - If IF_Valid && IF_Ready: IF_Valid<=0.
     - When IF_Valid is 0 or being consumed this edge: state<=HALT.
  3. Advance (IF_Valid==0 || IF_Ready==1):
     - IF_Instruction<=FetchInstruction; IF_PC<=PC; IF_PCPlus4<=PC+4.
     - IF_Valid<=1; PC<=PC+4; FetchCount<=FetchCount+1.
  4. Stall (IF_Valid && !IF_Ready): PC and all IF registers hold.
- Fetch latency: an instruction appears at IF_Valid one edge after PC addresses it. Throughput is one per cycle while IF_Ready=1.
- Redirect wins over stall and advance. Redirect in the same cycle decode accepts: the accept completes and the flush still clears IF_Valid.
- HALT:
  - IF_Valid=0; PC holds.
  - A legal Redirect returns to RUN with PC<=target.
  - An illegal Redirect goes to FAULT.
- FAULT: sticky until Reset. IF_Valid=0; PC and FetchCount frozen; Redirect ignored.
- Arithmetic: PC+4 wraps modulo 2^32. FetchCount wraps modulo 2^32.
- IF_Ready is ignored when IF_Valid=0.
- Redirect is ignored in IDLE.

Test Plan:
- Reset, then IF_Ready=1 constantly, memory word n = n: IF_Valid rises 2 edges after reset release. IF_PC sequence 0,4,8… with IF_Instruction 0,1,2…; FetchCount=3 after 3 loads.
- Hold IF_Ready=0 for 3 cycles while IF_Valid=1, IF_PC=8: IF_PC stays 8 and PC stays 12. After release, the next load is IF_PC=12 with no skipped or duplicated word.
- Redirect=1, RedirectTarget=0x40, same cycle IF_Ready=0: IF_Valid=0 next cycle, FetchAddress=0x40. The following edge loads IF_PC=0x40.
- RESET_PC=(MEM_WORDS-2)*4, IF_Ready=1: two instructions delivered, then Halted=1 and IF_Valid=0. A subsequent Redirect to 0x0 clears Halted and resumes fetch at 0.
- Redirect to 0x42, then separately to MEM_WORDS*4: each gives Fault=1 and IF_Valid=0. Later Redirects are ignored; only Reset clears Fault.
- Assert Reset mid-stall with IF_Valid=1, FetchCount=7: all outputs go to reset values immediately, before the next clock edge. Fetch restarts at RESET_PC.
